// File: rtl/wta_pkg.sv
// Shared types and helpers for the WTA gamma-cycle controller and its pipeline stages.
package wta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2
    } gamma_state_t;

    localparam int WTA_MAX_INPUTS = 256;
    localparam int WTA_IDX_MAX_W  = 8;

    typedef struct packed {
        logic                     found;
        logic [WTA_IDX_MAX_W-1:0] idx;
    } lsb_t;

    // Never returns 0 so that a 1-bit index port stays legal for tiny configurations.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic lsb_t lowest_set_idx(input logic [WTA_MAX_INPUTS-1:0] vec);
        lsb_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = WTA_MAX_INPUTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = WTA_IDX_MAX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wta_result_reg.sv
// One-entry valid/ready holding register; a load that finds the entry still held is
// dropped and recorded in a sticky overflow flag.
module wta_result_reg #(
    parameter int DATA_W = 8
) (
    input  logic              aclk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              overflow
);

    logic accept;

    assign accept = load && (!valid || ready);

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (ready) begin
                valid <= 1'b0;
            end
            if (load && valid && !ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wta_gamma_ctrl.sv
// Gamma-cycle sequencer for the WTA column: admission window, first-winner capture, result port.
// Optional winner timestamp output res_time is enabled by defining WTA_GAMMA_TIME_EN.
//
// state | meaning
// IDLE  | no gamma cycle in progress, WTA inputs gated off
// CLR   | one-clock WTA clear, counter and winner latch reset
// RUN   | gamma cycle in progress, counter advancing
module wta_gamma_ctrl
    import wta_pkg::*;
#(
    parameter  int GAMMA_CYCLE_WIDTH = 16,
    parameter  int PULSE_WIDTH       = 8,
    parameter  int NUM_INPUTS        = 16,
    localparam int IDX_W             = clog2_safe(NUM_INPUTS)
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [NUM_INPUTS-1:0] input_spikes,
    output logic [NUM_INPUTS-1:0] wta_in,
    input  logic [NUM_INPUTS-1:0] wta_out,
    output logic                  gamma_clr,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDX_W-1:0]      res_idx,
    output logic                  res_none,
    output logic                  overflow,
`ifdef WTA_GAMMA_TIME_EN
    output logic [GAMMA_CYCLE_WIDTH-1:0] res_time,
`endif
    output logic                  busy
);

    localparam logic [GAMMA_CYCLE_WIDTH-1:0] LAST    = GAMMA_CYCLE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [GAMMA_CYCLE_WIDTH-1:0] WIN_END = GAMMA_CYCLE_WIDTH'(GAMMA_CYCLE_WIDTH - PULSE_WIDTH);
`ifdef WTA_GAMMA_TIME_EN
    localparam int DATA_W = 1 + IDX_W + GAMMA_CYCLE_WIDTH;
`else
    localparam int DATA_W = 1 + IDX_W;
`endif

    gamma_state_t                 state, state_nxt;
    logic [GAMMA_CYCLE_WIDTH-1:0] cnt;
    logic                         win_en, publish;
    logic                         win_found;
    logic [IDX_W-1:0]             win_idx;
    lsb_t                         hit;
    logic [DATA_W-1:0]            cand_data, res_data;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A cycle always runs to its last count; run is only consulted at the boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = CLR;
            CLR:     state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = run ? CLR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gamma_clr = 1'b0;
        busy      = 1'b0;
        win_en    = 1'b0;
        publish   = 1'b0;
        case (state)
            CLR: begin
                gamma_clr = 1'b1;
                busy      = 1'b1;
            end
            RUN: begin
                busy    = 1'b1;
                win_en  = (cnt < WIN_END);
                publish = (cnt == LAST);
            end
            default: ;
        endcase
    end

    assign wta_in = win_en ? input_spikes : '0;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst)                                  cnt <= '0;
        else if (state == RUN && cnt != LAST)     cnt <= cnt + 1'b1;
        else                                      cnt <= '0;
    end

    assign hit = lowest_set_idx(WTA_MAX_INPUTS'(wta_out));

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            win_found <= 1'b0;
            win_idx   <= '0;
        end else if (state == CLR) begin
            win_found <= 1'b0;
            win_idx   <= '0;
        end else if (state == RUN && !win_found && hit.found) begin
            win_found <= 1'b1;
            win_idx   <= IDX_W'(hit.idx);
        end
    end

`ifdef WTA_GAMMA_TIME_EN
    logic [GAMMA_CYCLE_WIDTH-1:0] win_time;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst)                                              win_time <= '0;
        else if (state == CLR)                                win_time <= '0;
        else if (state == RUN && !win_found && hit.found)     win_time <= cnt;
    end

    assign cand_data = {~win_found, (win_found ? win_idx : '0), (win_found ? win_time : '0)};
    assign {res_none, res_idx, res_time} = res_data;
`else
    assign cand_data = {~win_found, (win_found ? win_idx : '0)};
    assign {res_none, res_idx} = res_data;
`endif

    wta_result_reg #(
        .DATA_W (DATA_W)
    ) u_result (
        .aclk      (aclk),
        .rst       (rst),
        .load      (publish),
        .load_data (cand_data),
        .valid     (res_valid),
        .ready     (res_ready),
        .data      (res_data),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_wta_gamma_ctrl.sv
// Scoreboard bench for wta_gamma_ctrl: self-timed gamma cycles, per-clock result port model.
module tb_wta_gamma_ctrl;

    localparam int N = 16;
    localparam int G = 16;
    localparam int P = 8;

    logic          aclk = 1'b0;
    logic          rst, run, res_ready;
    logic [N-1:0]  input_spikes, wta_in, wta_out;
    logic          gamma_clr, res_valid, res_none, overflow, busy;
    logic [3:0]    res_idx;
`ifdef WTA_GAMMA_TIME_EN
    logic [G-1:0]  res_time;
`endif

    typedef struct packed {
        logic        none;
        logic [3:0]  idx;
        logic [15:0] t;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    logic m_valid, m_ovf;

    always #5 aclk = ~aclk;

    wta_gamma_ctrl #(
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (P),
        .NUM_INPUTS        (N)
    ) dut (
        .aclk         (aclk),
        .rst          (rst),
        .run          (run),
        .input_spikes (input_spikes),
        .wta_in       (wta_in),
        .wta_out      (wta_out),
        .gamma_clr    (gamma_clr),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_idx      (res_idx),
        .res_none     (res_none),
        .overflow     (overflow),
`ifdef WTA_GAMMA_TIME_EN
        .res_time     (res_time),
`endif
        .busy         (busy)
    );

    function automatic logic [3:0] lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // One clock: update the result-port model at the edge, then check the registered outputs.
    task automatic tick(input bit pub, input res_t cand);
        bit   accept, drop;
        res_t junk;
        @(posedge aclk);
        accept = pub && (!m_valid || res_ready);
        drop   = pub && m_valid && !res_ready;
        if (m_valid && res_ready && exp_q.size() > 0) junk = exp_q.pop_front();
        if (accept) exp_q.push_back(cand);
        m_valid = accept || (m_valid && !res_ready);
        m_ovf   = m_ovf || drop;
        #1;
        total++;
        if (res_valid !== m_valid) begin
            bad++;
            $display("FAIL res_valid: got %b want %b at %0t", res_valid, m_valid, $time);
        end
        total++;
        if (overflow !== m_ovf) begin
            bad++;
            $display("FAIL overflow: got %b want %b at %0t", overflow, m_ovf, $time);
        end
        if (m_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: got empty queue want one entry at %0t", $time);
            end else if (res_idx !== exp_q[0].idx || res_none !== exp_q[0].none) begin
                bad++;
                $display("FAIL result: got idx=%0d none=%b want idx=%0d none=%b at %0t",
                         res_idx, res_none, exp_q[0].idx, exp_q[0].none, $time);
            end
`ifdef WTA_GAMMA_TIME_EN
            total++;
            if (exp_q.size() > 0 && res_time !== exp_q[0].t) begin
                bad++;
                $display("FAIL res_time: got %0d want %0d at %0t", res_time, exp_q[0].t, $time);
            end
`endif
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        run          = 1'b0;
        res_ready    = 1'b0;
        wta_out      = '0;
        input_spikes = 16'hFFFF;
        m_valid      = 1'b0;
        m_ovf        = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if ({wta_in, gamma_clr, res_valid, res_idx, res_none, overflow, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got wta_in=%h clr=%b v=%b idx=%0d none=%b ovf=%b busy=%b want all 0",
                     wta_in, gamma_clr, res_valid, res_idx, res_none, overflow, busy);
        end
        @(posedge aclk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, '0);
            total++;
            if (gamma_clr !== 1'b0 || busy !== 1'b0 || wta_in !== '0) begin
                bad++;
                $display("FAIL idle: got clr=%b busy=%b wta_in=%h want 0 0 0000", gamma_clr, busy, wta_in);
            end
        end
    endtask

    // From IDLE: raise run, land in the CLR clock.
    task automatic start_run();
        run = 1'b1;
        tick(1'b0, '0);
        total++;
        if (gamma_clr !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_clr: got clr=%b busy=%b want 1 1", gamma_clr, busy);
        end
    endtask

    // Precondition: sampling inside a CLR clock. Runs counters 0..G-1 and the following boundary clock.
    task automatic gamma_cycle(input int e1c, input logic [N-1:0] e1v, input int e2c, input logic [N-1:0] e2v,
                               input logic rdy_body, input logic rdy_last, input int drop_at,
                               input logic [N-1:0] spk, input string name);
        res_t cand;
        bit   found;
        cand      = '0;
        cand.none = 1'b1;
        found     = 1'b0;
        for (int c = 0; c < G; c++) begin
            tick(1'b0, '0);
            wta_out = (c == e1c) ? e1v : (c == e2c) ? e2v : '0;
            if (!found && c < G - 1 && wta_out != '0) begin
                found     = 1'b1;
                cand.none = 1'b0;
                cand.idx  = lowest(wta_out);
                cand.t    = 16'(c);
            end
            input_spikes = spk;
            res_ready    = (c == G - 1) ? rdy_last : rdy_body;
            if (c == drop_at) run = 1'b0;
            #1;
            total++;
            if (wta_in !== ((c < G - P) ? spk : '0)) begin
                bad++;
                $display("FAIL %s window c=%0d: got %h want %h", name, c, wta_in, (c < G - P) ? spk : '0);
            end
            total++;
            if (gamma_clr !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL %s run_state c=%0d: got clr=%b busy=%b want 0 1", name, c, gamma_clr, busy);
            end
        end
        wta_out = '0;
        tick(1'b1, cand);
        total++;
        if (gamma_clr !== run || busy !== run || wta_in !== '0) begin
            bad++;
            $display("FAIL %s boundary: got clr=%b busy=%b wta_in=%h want %b %b 0000",
                     name, gamma_clr, busy, wta_in, run, run);
        end
    endtask

    task automatic test_reset();
        do_reset();
        idle_ticks(50);
    endtask

    task automatic test_single_winner();
        res_ready = 1'b1;
        start_run();
        gamma_cycle(3, 16'h0020, -1, '0, 1'b1, 1'b1, -1, '0, "single");
        total++;
        if (res_valid !== 1'b1 || res_idx !== 4'd5 || res_none !== 1'b0) begin
            bad++;
            $display("FAIL single_result: got v=%b idx=%0d none=%b want 1 5 0", res_valid, res_idx, res_none);
        end
        gamma_cycle(-1, '0, -1, '0, 1'b1, 1'b1, -1, '0, "period");
    endtask

    task automatic test_tie();
        gamma_cycle(2, 16'h0300, 4, 16'h0001, 1'b1, 1'b1, -1, '0, "tie");
        total++;
        if (res_idx !== 4'd8) begin
            bad++;
            $display("FAIL tie_idx: got %0d want 8", res_idx);
        end
    endtask

    task automatic test_window();
        gamma_cycle(6, 16'h8000, -1, '0, 1'b1, 1'b1, -1, 16'h0001, "window");
        gamma_cycle(-1, '0, -1, '0, 1'b1, 1'b1, -1, 16'hA5C3, "window2");
        input_spikes = '0;
    endtask

    task automatic test_no_winner_stop();
        gamma_cycle(-1, '0, -1, '0, 1'b1, 1'b1, 4, '0, "stop");
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b1 || res_none !== 1'b1 || res_idx !== 4'd0) begin
            bad++;
            $display("FAIL stop_result: got busy=%b v=%b none=%b idx=%0d want 0 1 1 0",
                     busy, res_valid, res_none, res_idx);
        end
        idle_ticks(5);
    endtask

    task automatic test_backpressure();
        do_reset();
        start_run();
        gamma_cycle(3, 16'h0004, -1, '0, 1'b0, 1'b0, -1, '0, "bp_a1");
        gamma_cycle(5, 16'h0200, -1, '0, 1'b0, 1'b0, -1, '0, "bp_a2");
        total++;
        if (res_idx !== 4'd2 || overflow !== 1'b1 || res_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold: got idx=%0d ovf=%b v=%b want 2 1 1", res_idx, overflow, res_valid);
        end
        do_reset();
        start_run();
        gamma_cycle(3, 16'h0004, -1, '0, 1'b0, 1'b0, -1, '0, "bp_b1");
        gamma_cycle(5, 16'h0200, -1, '0, 1'b0, 1'b1, -1, '0, "bp_b2");
        total++;
        if (res_idx !== 4'd9 || overflow !== 1'b0 || res_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_swap: got idx=%0d ovf=%b v=%b want 9 0 1", res_idx, overflow, res_valid);
        end
        res_ready = 1'b1;
        gamma_cycle(1, 16'h1000, -1, '0, 1'b1, 1'b1, 0, '0, "bp_drain");
        idle_ticks(3);
    endtask

    initial begin
        test_reset();
        test_single_winner();
        test_tie();
        test_window();
        test_no_winner_stop();
        test_backpressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wta_gamma_ctrl.md
Name: wta_gamma_ctrl

Overview:
Sequences the winner-take-all column in fixed-length gamma cycles.
- Opens a spike-admission window at the start of each gamma cycle and gates raw input spikes into the WTA.
- Watches the WTA output, latches the first winner's index, and presents it on a valid/ready result port at the end of the cycle.
- Sits between the spike source and the wta_1 instance; also drives the WTA's gamma-boundary clear.

Parameters:
GAMMA_CYCLE_WIDTH, 16, clocks per gamma cycle (≥ PULSE_WIDTH+2)
PULSE_WIDTH, 8, spike pulse length in clocks; the admission window closes PULSE_WIDTH clocks before cycle end
NUM_INPUTS, 16, spike lines (≥ 2)

Ports:
aclk  in  1  clock
rst  in  1  reset
run  in  1  level; 1 = keep issuing gamma cycles
input_spikes  in  NUM_INPUTS  raw spikes from the encoder
wta_in  out  NUM_INPUTS  gated spikes to the WTA input
wta_out  in  NUM_INPUTS  WTA output spikes
gamma_clr  out  1  one-clock pulse at gamma cycle start; clears WTA state
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_idx  out  $clog2(NUM_INPUTS)  winner index
res_none  out  1  no winner in that cycle
overflow  out  1  sticky; a result was dropped
busy  out  1  FSM not IDLE

Behaviour:
- Reset: rst is asynchronous, active-high; clock is aclk. All outputs are 0, FSM is IDLE, counter is 0, overflow is 0.
- FSM states and transitions:
  - IDLE → CLR when run=1.
  - CLR lasts one clock; gamma_clr=1 and the counter loads 0.
  - CLR → RUN.
  - RUN → CLR at counter==GAMMA_CYCLE_WIDTH-1 if run=1; otherwise RUN → IDLE.
  - Dropping run mid-cycle finishes the current cycle; the cycle is never truncated.
- Counter: GAMMA_CYCLE_WIDTH-bit wide, increments in RUN only, no wrap within a cycle.
- Admission window: wta_in = input_spikes when state==RUN and counter < GAMMA_CYCLE_WIDTH-PULSE_WIDTH; otherwise wta_in = 0. It is combinational with no added latency.
- Winner capture:
  - In RUN, if no winner is latched yet and wta_out≠0, latch the index of the lowest set bit of wta_out.
  - Later wta_out activity in the same cycle is ignored.
  - Simultaneous spikes resolve to the lowest index.
- Result publication, on the last RUN clock (counter==GAMMA_CYCLE_WIDTH-1):
  - The candidate is the latched index, or res_none=1 with res_idx=0 if nothing was latched.
  - If res_valid=0, or res_valid=1 with res_ready=1 on the same clock: load the candidate and set res_valid=1 the next clock. The one-clock latency from cycle end is fixed.
  - If res_valid=1 and res_ready=0: discard the candidate, keep the old result, and set overflow=1. overflow stays set until rst.
- Handshake:
  - res_valid/res_idx/res_none stay stable while res_valid=1 and res_ready=0.
  - res_valid clears on the clock after a handshake unless a new load coincides.
- Winner latch clears in CLR.
- rst mid-cycle: immediate return to IDLE; any pending result is lost.

Optional Feature:
Macro: WTA_GAMMA_TIME_EN
- Defined:
  - Adds output res_time (GAMMA_CYCLE_WIDTH bits): the counter value at winner capture, loaded alongside res_idx.
  - res_time = 0 when res_none=1.
  - Reset value is 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package wta_pkg holds:
  - the state enum typedef (IDLE, CLR, RUN);
  - the function clog2_safe;
  - a function lowest_set_idx(vector), returning index plus a found flag.
- One sub-module: wta_result_reg, the one-entry valid/ready holding register with overflow detection. It is reused by later pipeline stages.
- The FSM, counter, window and capture logic stay in wta_gamma_ctrl.

Test Plan:
1. Reset/idle: rst=1, run=0, wta_in check → all outputs 0; with run=0 for 50 clocks, gamma_clr is never pulsed and wta_in stays 0 despite input_spikes=16'hFFFF.
2. Single winner: run=1, wta_out=16'h0020 at counter 3 → res_idx=5, res_none=0, res_valid rises exactly 1 clock after counter 15; gamma_clr pulses every 17 clocks.
3. Tie and later spikes: wta_out=16'h0300 at counter 2, then 16'h0001 at counter 4 → res_idx=8.
4. Window: input_spikes=16'h0001 held throughout → wta_in=1 for counters 0–7, 0 for counters 8–15 and in CLR.
5. Backpressure: res_ready=0 across two cycles with winners 2 then 9 → res_idx stays 2 and overflow=1. With res_ready=1 on the publication clock instead → res_idx=9 and overflow=0.
6. No winner and stop: wta_out=0 whole cycle → res_none=1, res_idx=0. Dropping run at counter 4 → cycle completes to 15, FSM goes IDLE, busy=0.
